// File: rtl/regbank_seq.sv
// regbank_seq: single-issue READ -> EXEC -> WRITE sequencer for an 8x8
// register bank with an ALU handshake and a stalled-ALU timeout.
// Optional build macro: REGBANK_SEQ_R0_ZERO_EN -- when defined, an operation
// whose write-back targets register 0 completes without a bank write.
module regbank_seq #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src1,
  input  logic [ADDR_W-1:0] req_src2,
  input  logic [ADDR_W-1:0] req_dest,
  input  logic              req_wb,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  output logic [ADDR_W-1:0] rf_addrdest,
  output logic [DATA_W-1:0] rf_datadest,
  output logic [2:0]        rf_control,
  output logic              rf_enable,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              op_done,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] dest_r;
  logic              wb_r;
  logic              skip_write_s;

  // Decide whether a write-back must be suppressed for the latched destination.
  always_comb begin
    skip_write_s = 1'b0;
`ifdef REGBANK_SEQ_R0_ZERO_EN
    if (dest_r == {ADDR_W{1'b0}}) begin
      skip_write_s = 1'b1;
    end else begin
      skip_write_s = 1'b0;
    end
`else
    skip_write_s = 1'b0;
`endif
  end

  // Accept a new operation only while idle and not held in reset.
  always_comb begin
    req_ready = 1'b0;
    if ((state_r == ST_IDLE) && rst_n) begin
      req_ready = 1'b1;
    end else begin
      req_ready = 1'b0;
    end
  end

  // Sequencer state, latched operation fields and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      dest_r      <= {ADDR_W{1'b0}};
      wb_r        <= 1'b0;
      rf_addr1    <= {ADDR_W{1'b0}};
      rf_addr2    <= {ADDR_W{1'b0}};
      rf_addrdest <= {ADDR_W{1'b0}};
      rf_datadest <= {DATA_W{1'b0}};
      rf_control  <= 3'b000;
      rf_enable   <= 1'b0;
      alu_start   <= 1'b0;
      op_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Strobes default low; addresses and write data hold their last value.
      rf_control <= 3'b000;
      rf_enable  <= 1'b0;
      alu_start  <= 1'b0;
      op_done    <= 1'b0;
      // A clear is overridden below if a timeout fires in the same cycle.
      if (err_clr) begin
        timeout_err <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            dest_r     <= req_dest;
            wb_r       <= req_wb;
            rf_addr1   <= req_src1;
            rf_addr2   <= req_src2;
            rf_control <= 3'b011;
            rf_enable  <= 1'b1;
            state_r    <= ST_READ;
          end
        end
        ST_READ: begin
          // Bank outputs are valid from the first EXEC cycle onward.
          alu_start <= 1'b1;
          cnt_r     <= {CNT_W{1'b0}};
          state_r   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (alu_done) begin
            // Done takes priority over a coincident timeout limit.
            cnt_r <= {CNT_W{1'b0}};
            if (wb_r && !skip_write_s) begin
              rf_addrdest <= dest_r;
              rf_datadest <= alu_result;
              rf_control  <= 3'b100;
              rf_enable   <= 1'b1;
              state_r     <= ST_WRITE;
            end else begin
              op_done <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else if (cnt_r == CNT_LAST) begin
            cnt_r       <= {CNT_W{1'b0}};
            timeout_err <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          op_done <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_seq.sv
// tb_regbank_seq: table vectors, hand-written corner sequences and random
// operations checked against a cycle-count model of the sequencer.
module tb_regbank_seq;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_src1, req_src2, req_dest;
  logic              req_wb;
  logic [ADDR_W-1:0] rf_addr1, rf_addr2, rf_addrdest;
  logic [DATA_W-1:0] rf_datadest;
  logic [2:0]        rf_control;
  logic              rf_enable;
  logic              alu_start;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic              op_done;
  logic              timeout_err;
  logic              err_clr;

  always #5 clk = ~clk;

  regbank_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_dest(req_dest), .req_wb(req_wb),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addrdest(rf_addrdest),
    .rf_datadest(rf_datadest), .rf_control(rf_control), .rf_enable(rf_enable),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .op_done(op_done), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  typedef struct {
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] d;
    logic       wb;
    int         delay;   // EXEC cycle carrying alu_done; 0 = never
    logic [7:0] res;
    logic       exp_to;  // expect a timeout
    int         exp_end; // cycle after accept where op_done / idle return is seen
    logic       exp_wr;  // expect one bank write
  } vec_t;

  int   n_total = 0;
  int   n_pass  = 0;
  logic err_exp = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                              input logic wb, input int delay, input logic [7:0] res,
                              input logic to, input int endc, input logic wr);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.d = d; v.wb = wb; v.delay = delay; v.res = res;
    v.exp_to = to; v.exp_end = endc; v.exp_wr = wr;
    return v;
  endfunction

  // Reference: accept at 0, READ at 1, EXEC from 2; done at EXEC cycle k
  // gives op_done at 3+k with a write, 2+k without; no done within TIMEOUT
  // EXEC cycles returns to idle at TIMEOUT+2 with an error.
  function automatic vec_t model(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                                 input logic wb, input int delay, input logic [7:0] res);
    logic wr;
`ifdef REGBANK_SEQ_R0_ZERO_EN
    wr = wb && (d != 3'd0);
`else
    wr = wb;
`endif
    if (delay == 0 || delay > TIMEOUT)
      return mk(s1, s2, d, wb, delay, res, 1'b1, TIMEOUT + 2, 1'b0);
    return mk(s1, s2, d, wb, delay, res, 1'b0, wr ? 3 + delay : 2 + delay, wr);
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int cyc, read_cyc, start_cyc, start_cnt, done_cyc, done_cnt, wr_cnt, bad_cnt, wait_n, exec_idx;
    logic [2:0] a1, a2, ad;
    logic [7:0] dd;
    a1 = 3'd0; a2 = 3'd0; ad = 3'd0; dd = 8'd0;
    wait_n = 0;
    while (!req_ready && wait_n < 50) begin
      step();
      wait_n++;
    end
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1; req_src1 = v.s1; req_src2 = v.s2; req_dest = v.d; req_wb = v.wb;
    step();
    req_valid = 1'b0;
    read_cyc = -1; start_cyc = -1; done_cyc = -1;
    start_cnt = 0; done_cnt = 0; wr_cnt = 0; bad_cnt = 0;
    cyc = 1;
    while (1) begin
      if (rf_enable && rf_control == 3'b011) begin
        if (read_cyc < 0) read_cyc = cyc;
        a1 = rf_addr1; a2 = rf_addr2;
      end else if (rf_enable && rf_control == 3'b100) begin
        wr_cnt++; ad = rf_addrdest; dd = rf_datadest;
      end else if (rf_enable || rf_control != 3'b000) begin
        bad_cnt++;
      end
      if (alu_start) begin
        start_cnt++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (op_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if ((cyc >= 2 && req_ready) || cyc >= 40) break;
      exec_idx   = (start_cyc < 0) ? 0 : cyc - start_cyc + 1;
      alu_done   = (v.delay != 0 && exec_idx == v.delay);
      alu_result = alu_done ? v.res : 8'($urandom);
      step();
      cyc++;
    end
    alu_done = 1'b0;
    chk({tag, "_read_cyc"}, read_cyc, 1);
    chk({tag, "_addr1"}, a1, v.s1);
    chk({tag, "_addr2"}, a2, v.s2);
    chk({tag, "_start_cyc"}, start_cyc, 2);
    chk({tag, "_start_cnt"}, start_cnt, 1);
    chk({tag, "_bad_strobe"}, bad_cnt, 0);
    if (v.exp_to) begin
      err_exp = 1'b1;
      chk({tag, "_to_end"}, cyc, v.exp_end);
      chk({tag, "_to_done_cnt"}, done_cnt, 0);
      chk({tag, "_to_wr_cnt"}, wr_cnt, 0);
    end else begin
      chk({tag, "_done_cyc"}, done_cyc, v.exp_end);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_wr_cnt"}, wr_cnt, v.exp_wr);
      if (v.exp_wr) begin
        chk({tag, "_addrdest"}, ad, v.d);
        chk({tag, "_datadest"}, dd, v.res);
      end
    end
    chk({tag, "_timeout_err"}, timeout_err, err_exp);
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    err_exp = 1'b0;
    chk({tag, "_err_cleared"}, timeout_err, 0);
  endtask

  vec_t tbl[8];

  initial begin
    int viol;
    vec_t v;
    rst_n = 1'b0; req_valid = 1'b0; req_src1 = 3'd0; req_src2 = 3'd0; req_dest = 3'd0;
    req_wb = 1'b0; alu_done = 1'b0; alu_result = 8'd0; err_clr = 1'b0;

    tbl[0] = mk(3'd1, 3'd2, 3'd3, 1'b1, 2,  8'hA5, 1'b0, 5,  1'b1);
    tbl[1] = mk(3'd4, 3'd4, 3'd5, 1'b0, 1,  8'h5A, 1'b0, 3,  1'b0);
    tbl[2] = mk(3'd6, 3'd7, 3'd6, 1'b1, 1,  8'h11, 1'b0, 4,  1'b1);
    tbl[3] = mk(3'd2, 3'd3, 3'd4, 1'b1, 0,  8'h00, 1'b1, 18, 1'b0);
    tbl[4] = mk(3'd5, 3'd1, 3'd2, 1'b1, 16, 8'hC3, 1'b0, 19, 1'b1);
`ifdef REGBANK_SEQ_R0_ZERO_EN
    tbl[5] = mk(3'd1, 3'd2, 3'd0, 1'b1, 1,  8'h3C, 1'b0, 3,  1'b0);
`else
    tbl[5] = mk(3'd1, 3'd2, 3'd0, 1'b1, 1,  8'h3C, 1'b0, 4,  1'b1);
`endif
    tbl[6] = mk(3'd7, 3'd0, 3'd1, 1'b0, 3,  8'h77, 1'b0, 5,  1'b0);
    tbl[7] = mk(3'd3, 3'd3, 3'd3, 1'b0, 17, 8'h99, 1'b1, 18, 1'b0);

    // Reset held for two cycles.
    step();
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_control", rf_control, 0);
    chk("rst_enable", rf_enable, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_op_done", op_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_addrs", {rf_addr1, rf_addr2, rf_addrdest}, 0);
    chk("rst_datadest", rf_datadest, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);

    // Table vectors, issued back to back; the error stays set after vector 3.
    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    clear_err("clr1");

    // Clear and a new timeout in the same cycle: the timeout wins.
    err_clr = 1'b1;
    run_op(tbl[3], "setwins");
    err_clr = 1'b0;
    clear_err("clr2");

    // Reset during EXEC with alu_done arriving around and after it.
    req_valid = 1'b1; req_src1 = 3'd3; req_src2 = 3'd5; req_dest = 3'd6; req_wb = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0; alu_done = 1'b1; alu_result = 8'hFF;
    step();
    chk("mid_rst_enable", rf_enable, 0);
    chk("mid_rst_control", rf_control, 0);
    chk("mid_rst_op_done", op_done, 0);
    chk("mid_rst_alu_start", alu_start, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rf_enable || op_done || alu_start) viol++;
    end
    alu_done = 1'b0;
    chk("mid_rst_late_done_ignored", viol, 0);
    chk("mid_rst_ready", req_ready, 1);
    err_exp = 1'b0;
    run_op(tbl[0], "post_rst");

    // Random operations against the model, with occasional error clears.
    for (int i = 0; i < 40; i++) begin
      v = model(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 19)), 8'($urandom));
      run_op(v, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) clear_err($sformatf("rndclr%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
